vreg_group_agu: RTL and testbench
=================================

# vreg_group_agu

Multi-operand vector register-group address generator. Accepts one instruction's register-group indices for up to NUM_OPS operands (e.g. vd, vs1, vs2) plus vlmul, and emits one beat per physical register of the group on a valid/ready stream toward the vector register file. Sits between instruction decode and the VRF read/write ports; generalises the single-operand group sequencer with per-operand enables, downstream back-pressure, beat tagging and an optional pending-request slot.

## Interface
- ADDR_WIDTH, 5, physical register address width (32 vector registers)
- NUM_OPS, 3, number of operand channels sequenced in lockstep
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort; drops the active group and any pending request
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when req_valid & req_ready
- req_vlmul  in  3  vlmul encoding of the request
- req_addr  in  NUM_OPS*ADDR_WIDTH  group index per channel; channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_op_en  in  NUM_OPS  per-channel enable
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts the beat
- out_addr  out  NUM_OPS*ADDR_WIDTH  physical register per channel, same packing
- out_op_en  out  NUM_OPS  latched channel enables for the active group
- out_beat  out  3  beat index within the group, 0..7
- out_last  out  1  final beat of the group
- idle  out  1  no active group and no pending request

## Operation
- Group calc: vlmul 0..3 -> beats = 1<<vlmul, base = (addr << vlmul) truncated to ADDR_WIDTH. vlmul 4..7 (reserved, fractional) -> beats = 1, base = addr unshifted.
- Beat k of an enabled channel = (base + k) mod 2^ADDR_WIDTH. Disabled channel: out_addr field = 0, never advances.
- States: IDLE, BUSY. IDLE -> BUSY on accept. BUSY: each out_valid & out_ready advances beat. On handshake of out_last: load the next request (pending slot, or the same-cycle accept) and stay BUSY, else -> IDLE.
- out_valid = 1 exactly in BUSY; out_addr/out_beat/out_last/out_op_en hold stable while out_valid & ~out_ready.
- out_last = (beat == beats-1); single-beat groups assert out_valid and out_last together.
- flush: next cycle IDLE, pending cleared, out_valid = 0; a request offered in the flush cycle is not accepted (req_ready = 0 while flush).
- Reset values: out_valid 0, out_addr 0, out_op_en 0, out_beat 0, out_last 0, idle 1; req_ready 1 once rst deasserts. Asserting rst mid-group discards the group immediately.

## Timing
- Accept at cycle N -> first beat valid cycle N+1 (registered, no combinational req->out path).
- Beats of one group issue back-to-back when out_ready stays high: a 1<<vlmul group completes in 1<<vlmul cycles.
- req_ready has no combinational dependence on req_valid; it may depend on out_ready only in the no-pending build (below).

## Configuration
- VREG_AGU_PENDING_EN defined: one-entry pending slot. req_ready = ~pending_valid & ~flush. Accept in IDLE loads active; accept in BUSY fills pending, except on the out_last handshake cycle with pending empty, where it loads active directly. Consecutive groups have zero bubble cycles; idle = IDLE & ~pending_valid.
- Not defined: no pending slot. req_ready = ~flush & (IDLE | (BUSY & out_last & out_ready)). Back-to-back still gap-free, but req_ready is combinational on out_ready.

## Structure
- Package vreg_agu_pkg: vlmul encoding constants, MAX_BEATS = 8, beat-index width, state enum {IDLE, BUSY}, request struct (vlmul, addr vector, op_en).
- Sub-module vreg_agu_group_calc: combinational base/beat-count computation for one channel, instantiated NUM_OPS times (beat count taken from channel 0).

## Test plan
- vlmul=2, req_addr ch0=3, ch1=1, ch2=5, all enabled, out_ready=1 -> beats 0..3 ch0 12..15, ch1 4..7, ch2 20..23, out_last on beat 3 only.
- vlmul=5, ch0=7 -> one beat, out_addr 7, out_last=1, out_beat=0.
- vlmul=3, ch0=4 (ADDR_WIDTH=5) -> base 32 truncates to 0, beats 0..7; req_op_en=3'b101 -> ch1 field 0 on all beats.
- vlmul=1 group, out_ready low on beat 0 for 3 cycles -> outputs stable, beat 1 follows the first ready cycle; total 2 handshakes.
- Two vlmul=1 requests offered back-to-back, out_ready=1 -> 4 consecutive beats, no bubble; with VREG_AGU_PENDING_EN second request accepted during beat 0.
- flush on beat 2 of a vlmul=3 group with a pending request -> out_valid 0 next cycle, idle=1, pending request never issued; rst low mid-group -> all outputs at reset values immediately.

Source files
------------

// File: rtl/vreg_agu_pkg.sv
// ---------------------------------------------------------------------------
// vreg_agu_pkg
// Shared definitions for the vector register-group address generator:
//   - vlmul encodings for the integral group sizes (4..7 are reserved or
//     fractional and always yield a single-beat group)
//   - MAX_BEATS / BEAT_W: largest group and width of the beat index
//   - state_t: sequencer state
//   - req_t: one request record (vlmul, packed group indices, enables)
//     sized for the default configuration
// Ports: none (package).
// ---------------------------------------------------------------------------
package vreg_agu_pkg;

   localparam int AGU_ADDR_WIDTH = 5;
   localparam int AGU_NUM_OPS    = 3;

   localparam logic [2:0] VLMUL_M1 = 3'd0;
   localparam logic [2:0] VLMUL_M2 = 3'd1;
   localparam logic [2:0] VLMUL_M4 = 3'd2;
   localparam logic [2:0] VLMUL_M8 = 3'd3;

   localparam int MAX_BEATS = 8;
   localparam int BEAT_W    = $clog2(MAX_BEATS);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic [2:0]                              vlmul;
      logic [AGU_NUM_OPS*AGU_ADDR_WIDTH-1:0]   addr;
      logic [AGU_NUM_OPS-1:0]                  op_en;
   } req_t;

endpackage

// File: rtl/vreg_group_agu_if.sv
// ---------------------------------------------------------------------------
// vreg_group_agu_if
// Request and beat streams of the register-group address generator.
//   master : instruction decode / VRF side (offers requests, sinks beats)
//   slave  : the address generator itself
// Signals:
//   req_valid/req_ready  request handshake
//   req_vlmul            vlmul encoding of the request
//   req_addr             group index per channel, channel i at [i*AW +: AW]
//   req_op_en            per-channel enable
//   out_valid/out_ready  beat handshake
//   out_addr             physical register per channel, same packing
//   out_op_en            enables latched for the active group
//   out_beat/out_last    beat index and final-beat flag
//   idle                 no active group and nothing pending
// ---------------------------------------------------------------------------
interface vreg_group_agu_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_OPS    = 3
);
   logic                           req_valid;
   logic                           req_ready;
   logic [2:0]                     req_vlmul;
   logic [NUM_OPS*ADDR_WIDTH-1:0]  req_addr;
   logic [NUM_OPS-1:0]             req_op_en;
   logic                           out_valid;
   logic                           out_ready;
   logic [NUM_OPS*ADDR_WIDTH-1:0]  out_addr;
   logic [NUM_OPS-1:0]             out_op_en;
   logic [2:0]                     out_beat;
   logic                           out_last;
   logic                           idle;

   modport master (
      output req_valid, req_vlmul, req_addr, req_op_en, out_ready,
      input  req_ready, out_valid, out_addr, out_op_en, out_beat, out_last, idle
   );

   modport slave (
      input  req_valid, req_vlmul, req_addr, req_op_en, out_ready,
      output req_ready, out_valid, out_addr, out_op_en, out_beat, out_last, idle
   );
endinterface

// File: rtl/vreg_agu_group_calc.sv
// ---------------------------------------------------------------------------
// vreg_agu_group_calc
// Combinational group geometry for one operand channel.
//   vlmul    in   vlmul encoding
//   addr     in   register-group index
//   base     out  first physical register of the group
//   last_idx out  index of the final beat (beats - 1)
// Integral vlmul scales the index by the group size and wraps within the
// register file; reserved/fractional encodings use the index as-is with a
// single beat.
// ---------------------------------------------------------------------------
module vreg_agu_group_calc
   import vreg_agu_pkg::*;
#(
   parameter int ADDR_WIDTH = 5
) (
   input  logic [2:0]            vlmul,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [ADDR_WIDTH-1:0] base,
   output logic [BEAT_W-1:0]     last_idx
);

   always_comb begin
      base     = addr;
      last_idx = '0;
      if (vlmul <= VLMUL_M8) begin
         base     = addr << vlmul[1:0];
         last_idx = BEAT_W'((32'd1 << vlmul[1:0]) - 32'd1);
      end
   end

endmodule

// File: rtl/vreg_group_agu.sv
// ---------------------------------------------------------------------------
// vreg_group_agu
// Multi-operand vector register-group address generator. Accepts one
// request (vlmul + per-channel group index + enables) and emits one beat per
// physical register of the group, all channels in lockstep.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   flush  synchronous abort of the active group and any pending request
//   bus    vreg_group_agu_if.slave (request and beat streams, idle)
// Build option: define VREG_AGU_PENDING_EN for a one-entry pending slot,
// which makes req_ready independent of out_ready.
// ---------------------------------------------------------------------------
module vreg_group_agu
   import vreg_agu_pkg::*;
#(
   parameter int ADDR_WIDTH = AGU_ADDR_WIDTH,
   parameter int NUM_OPS    = AGU_NUM_OPS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   vreg_group_agu_if.slave     bus
);

   localparam int AW_ALL = NUM_OPS * ADDR_WIDTH;

   typedef struct packed {
      logic [2:0]          vlmul;
      logic [AW_ALL-1:0]   addr;
      logic [NUM_OPS-1:0]  op_en;
   } slot_t;

   state_t               state_reg;
   logic [BEAT_W-1:0]    beat_reg;
   logic [BEAT_W-1:0]    last_idx_reg;
   logic                 last_reg;
   logic [AW_ALL-1:0]    addr_reg;
   logic [NUM_OPS-1:0]   op_en_reg;

   logic                 busy;
   logic                 out_fire;
   logic                 last_fire;
   logic                 accept;
   logic                 load_active;
   slot_t                req_in;
   slot_t                load_src;
   logic [AW_ALL-1:0]    load_addr;
   logic [AW_ALL-1:0]    inc_addr;
   logic [BEAT_W-1:0]    load_last_idx;

   assign busy      = (state_reg == BUSY);
   assign out_fire  = busy & bus.out_ready;
   assign last_fire = out_fire & last_reg;
   assign accept    = bus.req_valid & bus.req_ready;
   assign req_in    = {bus.req_vlmul, bus.req_addr, bus.req_op_en};

   // Per-channel group geometry for the request about to be loaded, and the
   // next address of the active group. Disabled channels stay at zero.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_OPS; gi++) begin : g_chan
         logic [ADDR_WIDTH-1:0] calc_base;
         logic [BEAT_W-1:0]     calc_last_idx;

         vreg_agu_group_calc #(
            .ADDR_WIDTH (ADDR_WIDTH)
         ) u_calc (
            .vlmul    (load_src.vlmul),
            .addr     (load_src.addr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
            .base     (calc_base),
            .last_idx (calc_last_idx)
         );

         assign load_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] =
            load_src.op_en[gi] ? calc_base : '0;
         assign inc_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] =
            op_en_reg[gi] ? addr_reg[gi*ADDR_WIDTH +: ADDR_WIDTH] + 1'b1 : '0;

         // All channels share vlmul, so channel 0 alone sets the beat count.
         if (gi == 0) begin : g_count
            assign load_last_idx = calc_last_idx;
         end else begin : g_nocount
            logic unused_calc_last;
            assign unused_calc_last = ^calc_last_idx;
         end
      end
   endgenerate

`ifdef VREG_AGU_PENDING_EN
   logic  pend_valid_reg;
   slot_t pend_reg;

   assign bus.req_ready = ~pend_valid_reg & ~flush;
   // The pending entry is older than anything on the request port, and the
   // port cannot accept while it is full, so it takes priority for loading.
   assign load_src      = pend_valid_reg ? pend_reg : req_in;
   assign load_active   = ~flush & ((~busy & accept) |
                                    (last_fire & (pend_valid_reg | accept)));
   assign bus.idle      = ~busy & ~pend_valid_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_valid_reg <= 1'b0;
         pend_reg       <= '0;
      end else if (flush) begin
         pend_valid_reg <= 1'b0;
      end else if (last_fire & pend_valid_reg) begin
         pend_valid_reg <= 1'b0;
      end else if (accept & busy & ~last_fire) begin
         pend_valid_reg <= 1'b1;
         pend_reg       <= req_in;
      end
   end
`else
   // Without a slot the port only opens when the active group is finishing
   // this cycle, hence the combinational path from out_ready.
   assign bus.req_ready = ~flush & (~busy | (last_reg & bus.out_ready));
   assign load_src      = req_in;
   assign load_active   = accept;
   assign bus.idle      = ~busy;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         beat_reg     <= '0;
         last_idx_reg <= '0;
         last_reg     <= 1'b0;
         addr_reg     <= '0;
         op_en_reg    <= '0;
      end else if (flush) begin
         state_reg <= IDLE;
      end else if (load_active) begin
         state_reg    <= BUSY;
         beat_reg     <= '0;
         last_idx_reg <= load_last_idx;
         last_reg     <= (load_last_idx == '0);
         addr_reg     <= load_addr;
         op_en_reg    <= load_src.op_en;
      end else if (last_fire) begin
         state_reg <= IDLE;
      end else if (out_fire) begin
         beat_reg <= beat_reg + BEAT_W'(1);
         last_reg <= ((beat_reg + BEAT_W'(1)) == last_idx_reg);
         addr_reg <= inc_addr;
      end
   end

   assign bus.out_valid = busy;
   assign bus.out_addr  = addr_reg;
   assign bus.out_op_en = op_en_reg;
   assign bus.out_beat  = 3'(beat_reg);
   assign bus.out_last  = last_reg;

endmodule

// File: tb/tb_vreg_group_agu.sv
// ---------------------------------------------------------------------------
// tb_vreg_group_agu
// Directed bench for vreg_group_agu: group geometry for several vlmul
// values, disabled channels, address wrap, back-pressure, back-to-back
// groups, flush with a queued request, and asynchronous reset mid-group.
// Works in both builds (VREG_AGU_PENDING_EN defined or not).
// ---------------------------------------------------------------------------
module tb_vreg_group_agu;
   import vreg_agu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   always #5 clk = ~clk;

   vreg_group_agu_if #(.ADDR_WIDTH(5), .NUM_OPS(3)) bus ();

   vreg_group_agu #(
      .ADDR_WIDTH (5),
      .NUM_OPS    (3)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   int total  = 0;
   int bad    = 0;
   int hs_cnt = 0;

   always @(posedge clk)
      if (rst && bus.out_valid && bus.out_ready) hs_cnt++;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] pk(input logic [4:0] a0, input logic [4:0] a1,
                                      input logic [4:0] a2);
      return {a2, a1, a0};
   endfunction

   function automatic req_t mk(input logic [2:0] vlmul, input logic [4:0] a2,
                               input logic [4:0] a1, input logic [4:0] a0,
                               input logic [2:0] en);
      req_t r;
      r.vlmul = vlmul;
      r.addr  = {a2, a1, a0};
      r.op_en = en;
      return r;
   endfunction

   task automatic drive(input req_t r);
      bus.req_valid = 1'b1;
      bus.req_vlmul = r.vlmul;
      bus.req_addr  = r.addr;
      bus.req_op_en = r.op_en;
   endtask

   // Offer a request to an idle DUT; on return the first beat is visible.
   task automatic offer(input string tag, input req_t r);
      drive(r);
      #1;
      chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
      $display("req %s vlmul=%0d addr=%h en=%b", tag, r.vlmul, r.addr, r.op_en);
      cyc();
      bus.req_valid = 1'b0;
   endtask

   task automatic chk_beat(input string tag, input logic [14:0] a, input int k,
                           input logic last, input logic [2:0] en);
      $display("beat %s k=%0d addr=%h last=%0d", tag, bus.out_beat, bus.out_addr, bus.out_last);
      chk($sformatf("%s.b%0d.valid", tag, k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("%s.b%0d.addr", tag, k), 32'(bus.out_addr), 32'(a));
      chk($sformatf("%s.b%0d.beat", tag, k), 32'(bus.out_beat), 32'(k));
      chk($sformatf("%s.b%0d.last", tag, k), 32'(bus.out_last), 32'(last));
      chk($sformatf("%s.b%0d.op_en", tag, k), 32'(bus.out_op_en), 32'(en));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, ".out_addr"}, 32'(bus.out_addr), 32'd0);
      chk({tag, ".out_op_en"}, 32'(bus.out_op_en), 32'd0);
      chk({tag, ".out_beat"}, 32'(bus.out_beat), 32'd0);
      chk({tag, ".out_last"}, 32'(bus.out_last), 32'd0);
      chk({tag, ".idle"}, 32'(bus.idle), 32'd1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, ".idle"}, 32'(bus.idle), 32'd1);
   endtask

   initial begin
      int h0;
      rst           = 1'b0;
      flush         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_vlmul = '0;
      bus.req_addr  = '0;
      bus.req_op_en = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) cyc();
      chk_reset_vals("rst");
      rst = 1'b1;
      #1;
      chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
      cyc();

      // vlmul=2, indices 3/1/5, all enabled: 12..15, 4..7, 20..23
      offer("t1", mk(VLMUL_M4, 5'd5, 5'd1, 5'd3, 3'b111));
      for (int k = 0; k < 4; k++) begin
         chk_beat("t1", pk(5'(12 + k), 5'(4 + k), 5'(20 + k)), k, k == 3, 3'b111);
         cyc();
      end
      chk_idle("t1.end");

      // Reserved vlmul: one unshifted beat
      offer("t2", mk(3'd5, 5'd9, 5'd2, 5'd7, 3'b001));
      chk_beat("t2", pk(5'd7, 5'd0, 5'd0), 0, 1'b1, 3'b001);
      cyc();
      chk_idle("t2.end");

      // vlmul=3, ch0=4 wraps to base 0; ch1 disabled; ch2=1 -> 8..15
      offer("t3", mk(VLMUL_M8, 5'd1, 5'd6, 5'd4, 3'b101));
      for (int k = 0; k < 8; k++) begin
         chk_beat("t3", pk(5'(k), 5'd0, 5'(8 + k)), k, k == 7, 3'b101);
         cyc();
      end
      chk_idle("t3.end");

      // Back-pressure on beat 0 for three cycles
      bus.out_ready = 1'b0;
      h0 = hs_cnt;
      offer("t4", mk(VLMUL_M2, 5'd0, 5'd0, 5'd2, 3'b001));
      for (int s = 0; s < 3; s++) begin
         chk_beat("t4.stall", pk(5'd4, 5'd0, 5'd0), 0, 1'b0, 3'b001);
         cyc();
      end
      bus.out_ready = 1'b1;
      chk_beat("t4", pk(5'd4, 5'd0, 5'd0), 0, 1'b0, 3'b001);
      cyc();
      chk_beat("t4", pk(5'd5, 5'd0, 5'd0), 1, 1'b1, 3'b001);
      cyc();
      chk("t4.handshakes", 32'(hs_cnt - h0), 32'd2);
      chk_idle("t4.end");

      // Two vlmul=1 groups back to back: 2,3 then 6,7 with no bubble
      drive(mk(VLMUL_M2, 5'd0, 5'd0, 5'd1, 3'b001));
      #1;
      chk("t5.a.req_ready", 32'(bus.req_ready), 32'd1);
      cyc();
      drive(mk(VLMUL_M2, 5'd0, 5'd0, 5'd3, 3'b001));
      #1;
      chk_beat("t5", pk(5'd2, 5'd0, 5'd0), 0, 1'b0, 3'b001);
`ifdef VREG_AGU_PENDING_EN
      chk("t5.b.ready_beat0", 32'(bus.req_ready), 32'd1);
      cyc();
      bus.req_valid = 1'b0;
      chk_beat("t5", pk(5'd3, 5'd0, 5'd0), 1, 1'b1, 3'b001);
      chk("t5.pend_full.req_ready", 32'(bus.req_ready), 32'd0);
      cyc();
`else
      chk("t5.b.ready_beat0", 32'(bus.req_ready), 32'd0);
      cyc();
      chk_beat("t5", pk(5'd3, 5'd0, 5'd0), 1, 1'b1, 3'b001);
      chk("t5.b.ready_last", 32'(bus.req_ready), 32'd1);
      cyc();
      bus.req_valid = 1'b0;
`endif
      chk_beat("t5.b", pk(5'd6, 5'd0, 5'd0), 0, 1'b0, 3'b001);
      cyc();
      chk_beat("t5.b", pk(5'd7, 5'd0, 5'd0), 1, 1'b1, 3'b001);
      cyc();
      chk_idle("t5.end");

      // Flush on beat 2 of a vlmul=3 group with a second request queued
      offer("t6", mk(VLMUL_M8, 5'd0, 5'd0, 5'd1, 3'b001));
      drive(mk(VLMUL_M1, 5'd0, 5'd0, 5'd2, 3'b001));
      #1;
      chk_beat("t6", pk(5'd8, 5'd0, 5'd0), 0, 1'b0, 3'b001);
      cyc();
      chk_beat("t6", pk(5'd9, 5'd0, 5'd0), 1, 1'b0, 3'b001);
      cyc();
      chk_beat("t6", pk(5'd10, 5'd0, 5'd0), 2, 1'b0, 3'b001);
      flush = 1'b1;
      #1;
      chk("t6.flush.req_ready", 32'(bus.req_ready), 32'd0);
      cyc();
      flush         = 1'b0;
      bus.req_valid = 1'b0;
      chk_idle("t6.after_flush");
      for (int s = 0; s < 3; s++) begin
         cyc();
         chk($sformatf("t6.no_pending_issue%0d", s), 32'(bus.out_valid), 32'd0);
      end

      // Asynchronous reset in the middle of a group
      offer("t7", mk(VLMUL_M4, 5'd5, 5'd1, 5'd3, 3'b111));
      chk_beat("t7", pk(5'd12, 5'd4, 5'd20), 0, 1'b0, 3'b111);
      cyc();
      chk_beat("t7", pk(5'd13, 5'd5, 5'd21), 1, 1'b0, 3'b111);
      rst = 1'b0;
      #1;
      chk_reset_vals("t7.rst");
      cyc();
      rst = 1'b1;
      #1;
      chk("t7.req_ready", 32'(bus.req_ready), 32'd1);
      cyc();
      chk_idle("t7.end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
